// File: rtl/fft_out_serializer.sv
// fft_out_serializer
//  Captures one reordered NPOINT-sample complex frame, presented in parallel with
//  a 1-cycle frame_vld pulse. Streams it out LANES samples per beat in natural bin
//  order over a valid/ready handshake. Samples pass through unmodified.
//
//  Optional feature macro: FFT_SER_DBLBUF_EN
//   defined   : a second frame buffer (pending slot) accepts a frame that arrives
//               while streaming; it is streamed right after the active frame.
//   undefined : single buffer; a frame arriving mid-stream is dropped.
//  A frame arriving on the last-beat accept cycle is always taken, and a dropped
//  frame sets the sticky ovf flag.
//
//  Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   frame_vld            1-cycle pulse: frame_re/frame_im hold a complete frame
//   frame_re, frame_im   NPOINT x WIDTH reordered frame, index = FFT bin
//   ovf_clr              synchronous clear of ovf
//   out_ready            downstream accepts the current beat
//   out_valid            beat on out_re/out_im is valid
//   out_re, out_im       LANES x WIDTH, lane l = bin out_beat*LANES + l
//   out_beat             current beat index 0..BEATS-1
//   out_last             high with out_valid on beat BEATS-1
//   busy                 a frame is held (streaming or pending)
//   ovf                  sticky: a frame_vld was dropped
module fft_out_serializer #(
    parameter  int unsigned WIDTH  = 13,
    parameter  int unsigned NPOINT = 512,
    parameter  int unsigned LANES  = 16,
    localparam int unsigned BEATS  = NPOINT / LANES,
    localparam int unsigned BW     = $clog2(BEATS)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         frame_vld,
    input  logic [NPOINT-1:0][WIDTH-1:0] frame_re,
    input  logic [NPOINT-1:0][WIDTH-1:0] frame_im,
    input  logic                         ovf_clr,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [LANES-1:0][WIDTH-1:0]  out_re,
    output logic [LANES-1:0][WIDTH-1:0]  out_im,
    output logic [BW-1:0]                out_beat,
    output logic                         out_last,
    output logic                         busy,
    output logic                         ovf
);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t state;

    // Active frame storage (not reset: contents are don't-care until loaded)
    logic [NPOINT-1:0][WIDTH-1:0] act_re;
    logic [NPOINT-1:0][WIDTH-1:0] act_im;

    // Active frame viewed as BEATS beats of LANES samples
    logic [LANES-1:0][WIDTH-1:0] act_beat_re [BEATS];
    logic [LANES-1:0][WIDTH-1:0] act_beat_im [BEATS];

    logic                        accept;
    logic                        last_acc;
    logic                        ld_act;
    logic                        swap;
    logic                        drop;
    logic                        pend_vld_nxt;
    logic                        go_idle;
    logic                        busy_nxt;
    logic [BW-1:0]               beat_inc;
    logic [LANES-1:0][WIDTH-1:0] restart_re;
    logic [LANES-1:0][WIDTH-1:0] restart_im;

    // Beat view of the active buffer
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign act_beat_re[b][l] = act_re[b*LANES + l];
            assign act_beat_im[b][l] = act_im[b*LANES + l];
        end
    end

    // Handshake decode shared by both buffer configurations
    always_comb begin
        accept   = out_valid && out_ready;
        last_acc = accept && out_last;
        beat_inc = out_beat + BW'(1);
        go_idle  = last_acc && !ld_act && !swap;
        busy_nxt = ((state == S_STREAM) && !go_idle) ||
                   ((state == S_IDLE) && frame_vld) ||
                   pend_vld_nxt;
    end

`ifdef FFT_SER_DBLBUF_EN
    logic                         pend_vld;
    logic                         ld_pend;
    logic [NPOINT-1:0][WIDTH-1:0] pend_re;
    logic [NPOINT-1:0][WIDTH-1:0] pend_im;

    // Frame routing: straight to active when nothing is queued, else to pending
    always_comb begin
        swap         = last_acc && pend_vld;
        ld_act       = frame_vld && ((state == S_IDLE) || (last_acc && !pend_vld));
        // In STREAM: pending fills when empty mid-stream, or when it is being
        // swapped out on the last-beat accept
        ld_pend      = frame_vld && (state == S_STREAM) && (last_acc == pend_vld);
        drop         = frame_vld && (state == S_STREAM) && !last_acc && pend_vld;
        pend_vld_nxt = ld_pend || (pend_vld && !swap);
        restart_re   = swap ? pend_re[LANES-1:0] : frame_re[LANES-1:0];
        restart_im   = swap ? pend_im[LANES-1:0] : frame_im[LANES-1:0];
    end

    // Pending slot occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_vld <= 1'b0;
        end else begin
            pend_vld <= pend_vld_nxt;
        end
    end

    // Frame buffers
    always_ff @(posedge clk) begin
        if (ld_act) begin
            act_re <= frame_re;
            act_im <= frame_im;
        end else if (swap) begin
            act_re <= pend_re;
            act_im <= pend_im;
        end
        if (ld_pend) begin
            pend_re <= frame_re;
            pend_im <= frame_im;
        end
    end
`else
    // Single buffer: only IDLE or the last-beat accept can take a new frame
    always_comb begin
        swap         = 1'b0;
        pend_vld_nxt = 1'b0;
        ld_act       = frame_vld && ((state == S_IDLE) || last_acc);
        drop         = frame_vld && (state == S_STREAM) && !last_acc;
        restart_re   = frame_re[LANES-1:0];
        restart_im   = frame_im[LANES-1:0];
    end

    // Frame buffer
    always_ff @(posedge clk) begin
        if (ld_act) begin
            act_re <= frame_re;
            act_im <= frame_im;
        end
    end
`endif

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_beat  <= '0;
            out_re    <= '0;
            out_im    <= '0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            busy <= busy_nxt;

            // A drop in the same cycle as ovf_clr keeps the flag set
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (frame_vld) begin
                        state     <= S_STREAM;
                        out_valid <= 1'b1;
                        out_beat  <= '0;
                        out_last  <= 1'b0;
                        out_re    <= restart_re;
                        out_im    <= restart_im;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (out_last) begin
                            if (ld_act || swap) begin
                                // Back-to-back frame: beat 0 with no bubble
                                out_beat <= '0;
                                out_last <= 1'b0;
                                out_re   <= restart_re;
                                out_im   <= restart_im;
                            end else begin
                                state     <= S_IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                out_beat  <= '0;
                            end
                        end else begin
                            out_beat <= beat_inc;
                            out_last <= (beat_inc == BW'(BEATS - 1));
                            out_re   <= act_beat_re[beat_inc];
                            out_im   <= act_beat_im[beat_inc];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer
//  Self-checking bench for fft_out_serializer. Every frame the DUT should stream is
//  pushed as 32 expected beats into a queue when it is pulsed; a negedge monitor pops
//  and compares on each accepted beat and checks that stalled beats hold still.
//  Build with +define+FFT_SER_DBLBUF_EN to check the double-buffered variant.
module tb_fft_out_serializer;

    localparam int unsigned W  = 13;
    localparam int unsigned N  = 512;
    localparam int unsigned L  = 16;
    localparam int unsigned B  = 32;
    localparam int unsigned BW = 5;
    localparam int unsigned AW = 9;
    localparam int unsigned LW = 4;

`ifdef FFT_SER_DBLBUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    typedef struct packed {
        logic [BW-1:0]       beat;
        logic                last;
        logic [L-1:0][W-1:0] re;
        logic [L-1:0][W-1:0] im;
    } beat_t;

    typedef struct {
        int kind;
        int rm;
        int p2_beat;
        int p2_kind;
        bit p2_push;
        bit exp_ovf;
    } case_t;

    logic                clk = 1'b0;
    logic                rstn;
    logic                frame_vld;
    logic [N-1:0][W-1:0] fre;
    logic [N-1:0][W-1:0] fim;
    logic                ovf_clr;
    logic                out_ready;
    logic                out_valid;
    logic [L-1:0][W-1:0] out_re;
    logic [L-1:0][W-1:0] out_im;
    logic [BW-1:0]       out_beat;
    logic                out_last;
    logic                busy;
    logic                ovf;

    int    total = 0;
    int    bad   = 0;
    int    rmode = 0;
    beat_t q[$];
    case_t tbl[5];

    fft_out_serializer dut (
        .clk       (clk),
        .rstn      (rstn),
        .frame_vld (frame_vld),
        .frame_re  (fre),
        .frame_im  (fim),
        .ovf_clr   (ovf_clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // out_ready pattern: 0 always high, 1 toggle, 2 random, other held low
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: compare accepted beats, check stalled beats stay put
    initial begin
        beat_t        e;
        logic [511:0] held;
        bit           stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_stable", 512'({out_valid, out_beat, out_last, out_re, out_im}), held);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_beat: got beat %0d, want no beat", out_beat);
                    end else begin
                        e = q.pop_front();
                        chk("beat_data", 512'({out_beat, out_last, out_re, out_im}), 512'(e));
                    end
                end
                stall = out_valid && !out_ready;
                held  = 512'({out_valid, out_beat, out_last, out_re, out_im});
            end
        end
    end

    task automatic fill_frame(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: begin
                    fre[AW'(i)] = W'(i);
                    fim[AW'(i)] = W'(-i);
                end
                1: begin
                    fre[AW'(i)] = W'(i * 29 + 3);
                    fim[AW'(i)] = W'(4095 - i * 13);
                end
                default: begin
                    fre[AW'(i)] = W'($urandom);
                    fim[AW'(i)] = W'($urandom);
                end
            endcase
        end
        if (kind == 1) begin
            fre[0]            = 13'h1000;
            fim[AW'(N - 1)]   = 13'h0fff;
        end
    endtask

    // Expected stream: beat k lane l carries bin k*L + l
    task automatic push_frame();
        beat_t e;
        for (int k = 0; k < B; k++) begin
            e.beat = BW'(k);
            e.last = (k == B - 1);
            for (int l = 0; l < L; l++) begin
                e.re[LW'(l)] = fre[AW'(k * L + l)];
                e.im[LW'(l)] = fim[AW'(k * L + l)];
            end
            q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1
    task automatic pulse(input int kind, input bit push);
        fill_frame(kind);
        if (push) push_frame();
        frame_vld = 1'b1;
        @(posedge clk);
        #1;
        frame_vld = 1'b0;
    endtask

    task automatic wait_beat(input int k);
        int n;
        n = 0;
        while (!(out_valid && (out_beat == BW'(k))) && (n < 400)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL wait_beat: got beat %0d valid %0b, want beat %0d", out_beat, out_valid, k);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || out_valid) && (n < 3000)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain: got busy %0b valid %0b, want idle", busy, out_valid);
        end
        chk("queue_empty", 512'(q.size()), 512'(0));
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        frame_vld = 1'b0;
        ovf_clr   = 1'b0;
        fre       = '0;
        fim       = '0;
        rmode     = 0;

        // {kind, ready mode, 2nd pulse beat, 2nd kind, 2nd expected, ovf after}
        tbl[0] = '{1, 0, -1, 0, 1'b0, 1'b0};
        tbl[1] = '{2, 2, -1, 0, 1'b0, 1'b0};
        tbl[2] = '{1, 0, 31, 2, 1'b1, 1'b0};
        tbl[3] = '{2, 0, 10, 1, DBL,  !DBL};
        tbl[4] = '{0, 1, 20, 2, DBL,  !DBL};

        // Reset state
        #12;
        chk("rst_valid", 512'(out_valid), 512'(0));
        chk("rst_last", 512'(out_last), 512'(0));
        chk("rst_beat", 512'(out_beat), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_ovf", 512'(ovf), 512'(0));
        chk("rst_data", 512'({out_re, out_im}), 512'(0));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame at full rate: 32 beats in 32 cycles
        pulse(0, 1'b1);
        chk("t1_first_valid", 512'({out_valid, out_beat}), 512'({1'b1, 5'd0}));
        repeat (31) begin
            @(posedge clk);
            #1;
        end
        chk("t1_beat31", 512'({out_valid, out_last, out_beat}), 512'({1'b1, 1'b1, 5'd31}));
        @(posedge clk);
        #1;
        chk("t1_done", 512'({out_valid, busy}), 512'(0));
        chk("t1_queue", 512'(q.size()), 512'(0));

        // Toggled ready with 5-cycle stalls on beat 3 and beat 31
        rmode = 1;
        pulse(1, 1'b1);
        wait_beat(3);
        rmode = 3;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("t2_stall3", 512'({out_valid, out_last, out_beat}), 512'({1'b1, 1'b0, 5'd3}));
        rmode = 1;
        wait_beat(31);
        rmode = 3;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("t2_stall31", 512'({out_valid, out_last, out_beat}), 512'({1'b1, 1'b1, 5'd31}));
        rmode = 0;
        drain();

        // Table-driven frame scenarios
        for (int c = 0; c < 5; c++) begin
            clear_ovf();
            rmode = tbl[c].rm;
            pulse(tbl[c].kind, 1'b1);
            if (tbl[c].p2_beat >= 0) begin
                wait_beat(tbl[c].p2_beat);
                pulse(tbl[c].p2_kind, tbl[c].p2_push);
                if (tbl[c].p2_beat == B - 1) begin
                    chk($sformatf("case%0d_no_bubble", c), 512'({out_valid, out_beat}),
                        512'({1'b1, 5'd0}));
                end
            end
            drain();
            chk($sformatf("case%0d_ovf", c), 512'(ovf), 512'(tbl[c].exp_ovf));
            chk($sformatf("case%0d_busy", c), 512'(busy), 512'(0));
        end

        // Second pulse at beat 10, third at beat 12
        rmode = 0;
        clear_ovf();
        pulse(1, 1'b1);
        wait_beat(10);
        pulse(2, DBL);
`ifdef FFT_SER_DBLBUF_EN
        chk("t4_ovf_after_2nd", 512'(ovf), 512'(0));
`endif
        wait_beat(12);
        pulse(0, 1'b0);
        chk("t4_ovf_after_3rd", 512'(ovf), 512'(1));
        wait_beat(31);
        @(posedge clk);
        #1;
        chk("t4_after_frame1", 512'({out_valid, out_beat}), 512'({DBL, 5'd0}));
        drain();
        chk("t4_ovf_sticky", 512'(ovf), 512'(1));

        // ovf_clr coincident with a drop, then ovf_clr alone
        clear_ovf();
        chk("t5_clr_start", 512'(ovf), 512'(0));
        pulse(1, 1'b1);
        wait_beat(2);
        pulse(2, DBL);
        wait_beat(4);
        pulse(0, 1'b0);
        chk("t5_drop_sets", 512'(ovf), 512'(1));
        wait_beat(6);
        ovf_clr = 1'b1;
        pulse(2, 1'b0);
        ovf_clr = 1'b0;
        chk("t5_set_wins", 512'(ovf), 512'(1));
        clear_ovf();
        chk("t5_clr", 512'(ovf), 512'(0));
        drain();

        // Reset at beat 17, then a fresh frame
        pulse(2, 1'b1);
        wait_beat(17);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 512'(out_valid), 512'(0));
        chk("t6_rst_busy", 512'(busy), 512'(0));
        q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_after_rst", 512'({out_valid, busy, ovf, out_beat}), 512'(0));
        pulse(1, 1'b1);
        chk("t6_fresh_start", 512'({out_valid, out_beat}), 512'({1'b1, 5'd0}));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
